// File: rtl/spi_mc_pkg.sv
// Shared types and helpers for the multi-mode SPI master.
package spi_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Chip-select index width that stays legal for a single slave.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_mc_sclk_gen.sv
// Half-period timer for the SPI master: one tick every HALF clocks while running,
// split into leading/trailing SCLK edge strobes until NUM_EDGES edges have been issued.
module spi_mc_sclk_gen
    import spi_mc_pkg::*;
#(
    parameter int HALF = 2,
    parameter int NUM_EDGES = 16,
    localparam int EC_W = $clog2(NUM_EDGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            tick,
    output logic            lead_edge,
    output logic            trail_edge,
    output logic [EC_W-1:0] edge_cnt
);

    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt;
    logic             edges_left;

    assign tick       = (cnt == CNT_W'(HALF - 1));
    assign edges_left = (edge_cnt != EC_W'(NUM_EDGES));
    // Even edge numbers leave the idle level, odd ones return to it.
    assign lead_edge  = tick && edges_left && !edge_cnt[0];
    assign trail_edge = tick && edges_left && edge_cnt[0];

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt      <= '0;
            edge_cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && edges_left) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-transfer CPOL/CPHA, configurable width/bit order and one-hot
// active-low chip selects; start/done handshake on the CPU side.
module spi_master_mc
    import spi_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CS_W = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int HALF = CLK_DIV / 2;
    localparam int NUM_EDGES = 2 * DATA_W;
    localparam int EC_W = $clog2(NUM_EDGES + 1);

    state_t            state;
    spi_mode_t         mode;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              tick;
    logic              lead_edge;
    logic              trail_edge;
    logic [EC_W-1:0]   edge_cnt;
    logic              cs_ok;
    logic              last_edge;
    logic              edges_done;
    logic              sample;
    logic              drive;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    spi_mc_sclk_gen #(
        .HALF      (HALF),
        .NUM_EDGES (NUM_EDGES)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (busy),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .edge_cnt   (edge_cnt)
    );

    assign cs_ok      = (int'(cs_sel) < NUM_CS);
    assign last_edge  = (edge_cnt == EC_W'(NUM_EDGES - 1));
    assign edges_done = (edge_cnt == EC_W'(NUM_EDGES));
    // CPHA=0 presents the first bit before any edge, so its final trailing edge has nothing left to drive.
    assign sample     = mode.cpha ? trail_edge : lead_edge;
    assign drive      = mode.cpha ? lead_edge : (trail_edge && !last_edge);

    // NOTE: every register here, outputs included, is state updated with <= in this one block,
    // so all pins change together one clock after the decision that caused them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
            tx_sh   <= '0;
            rx_sh   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && cs_ok) begin
                        state <= SETUP;
                        mode  <= '{cpol: cpol, cpha: cpha};
                        busy  <= 1'b1;
                        sclk  <= cpol;
                        cs_n  <= ~(NUM_CS'(1) << cs_sel);
                        rx_sh <= '0;
                        if (!cpha) begin
                            mosi  <= first_bit(tx_data);
                            tx_sh <= shift_out(tx_data);
                        end else begin
                            tx_sh <= tx_data;
                        end
                    end
                end
                SETUP, XFER: begin
                    if (lead_edge || trail_edge) begin
                        sclk <= ~sclk;
                    end
                    if (sample) begin
                        rx_sh <= shift_in(rx_sh, miso);
                    end
                    if (drive) begin
                        mosi  <= first_bit(tx_sh);
                        tx_sh <= shift_out(tx_sh);
                    end
                    if (state == SETUP && tick) begin
                        state <= XFER;
                    end else if (state == XFER && tick && edges_done) begin
                        state <= HOLD;
                        sclk  <= mode.cpol;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cs_n    <= '1;
                        mosi    <= 1'b0;
                        rx_data <= rx_sh;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a vector table of single transfers against a bench
// slave, plus hand-written sequences for back-to-back, reset abort, bad CS and 16-bit LSB-first.
module tb_spi_master_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cpol, cpha;
    // Main instance: DATA_W=8, CLK_DIV=4, NUM_CS=4, MSB first.
    logic       start, busy, done, sclk, mosi, miso;
    logic [1:0] cs_sel;
    logic [7:0] tx_data, rx_data;
    logic [3:0] cs_n;
    // 16-bit LSB-first instance, miso looped back.
    logic        start16, busy16, done16, sclk16, mosi16;
    logic [1:0]  cs_sel16;
    logic [15:0] tx16, rx16;
    logic [3:0]  cs_n16;
    // Three-slave instance, miso looped back.
    logic       start3, busy3, done3, sclk3, mosi3;
    logic [1:0] cs_sel3;
    logic [7:0] tx3, rx3;
    logic [2:0] cs_n3;

    spi_master_mc #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
        .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n));

    spi_master_mc #(.DATA_W(16), .CLK_DIV(4), .NUM_CS(4), .MSB_FIRST(1'b0)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel16),
        .tx_data(tx16), .rx_data(rx16), .busy(busy16), .done(done16), .sclk(sclk16),
        .mosi(mosi16), .miso(mosi16), .cs_n(cs_n16));

    spi_master_mc #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(3), .MSB_FIRST(1'b1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel3),
        .tx_data(tx3), .rx_data(rx3), .busy(busy3), .done(done3), .sclk(sclk3),
        .mosi(mosi3), .miso(mosi3), .cs_n(cs_n3));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Bench slave for the main instance: MSB-first, mode taken from tb_pol/tb_pha.
    logic       tb_pol = 1'b0, tb_pha = 1'b0, sl_loop = 1'b1;
    logic [7:0] sl_word = '0, sl_rx = '0;
    logic       sl_miso = 1'b0, sl_act = 1'b0, sl_prev = 1'b0;
    int         sl_idx = 0;
    logic       mon_sclk = 1'b0, mon_mosi = 1'b0;
    int         mosi_bad = 0;

    assign miso = sl_loop ? mosi : sl_miso;

    always @(negedge clk) begin
        if (&cs_n) begin
            sl_act = 1'b0;
        end else if (!sl_act) begin
            sl_act = 1'b1;
            sl_idx = 0;
            sl_rx  = '0;
            if (!tb_pha) begin
                sl_miso = sl_word[7];
                sl_idx  = 1;
            end
        end else if (sclk != sl_prev) begin
            if ((sclk != tb_pol) == !tb_pha) begin
                sl_rx = {sl_rx[6:0], mosi};
            end else if (sl_idx < 8) begin
                sl_miso = sl_word[7 - sl_idx];
                sl_idx++;
            end
        end
        sl_prev = sclk;
        // mosi may only move while sclk rests at cpol (CPHA=0) or together with a leading edge (CPHA=1).
        if (!(&cs_n) && mosi != mon_mosi) begin
            if (tb_pha ? !(sclk != mon_sclk && sclk != tb_pol) : (sclk != tb_pol)) mosi_bad++;
        end
        mon_sclk = sclk;
        mon_mosi = mosi;
    end

    typedef struct {
        logic       pol;
        logic       pha;
        logic [1:0] sel;
        logic [7:0] tx;
        logic       loop;
        logic [7:0] sword;
        logic [7:0] exp_rx;
        logic [3:0] exp_csn;
    } vec_t;

    vec_t vecs[4];

    task automatic apply_vec(input vec_t v, input string tag);
        int busy_cyc = 0, csn_bad = 0, n_done = 0, leads = 0, bad0;
        logic [7:0] rx_at_done = '0;
        logic ps;
        @(negedge clk);
        tb_pol = v.pol; tb_pha = v.pha; sl_loop = v.loop; sl_word = v.sword;
        cpol = v.pol; cpha = v.pha; cs_sel = v.sel; tx_data = v.tx; start = 1'b1;
        bad0 = mosi_bad;
        @(negedge clk);
        start = 1'b0;
        ps = sclk;
        for (int i = 0; i < 200; i++) begin
            if (busy) begin
                busy_cyc++;
                if (cs_n !== v.exp_csn) csn_bad++;
            end
            if (sclk !== ps && sclk !== v.pol) leads++;
            ps = sclk;
            if (done) begin
                n_done++;
                rx_at_done = rx_data;
                break;
            end
            @(negedge clk);
        end
        repeat (4) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check({tag, " busy cycles"}, busy_cyc, 36);
        check({tag, " cs_n during busy"}, csn_bad, 0);
        check({tag, " done pulses"}, n_done, 1);
        check({tag, " rx_data"}, rx_at_done, v.exp_rx);
        check({tag, " slave got tx"}, sl_rx, v.tx);
        check({tag, " leading edges"}, leads, 8);
        check({tag, " mosi timing"}, mosi_bad - bad0, 0);
        check({tag, " idle sclk"}, sclk, v.pol);
        check({tag, " idle cs_n"}, cs_n, 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rises, nd, gap, b, leads, first_bit_seen;
        logic prev_b, ps, first_bit;
        logic [7:0] rx1, rx2, rxd;
        logic [15:0] cap, rxd16;

        rst = 1'b1; cpol = 1'b0; cpha = 1'b0;
        start = 1'b0; cs_sel = '0; tx_data = '0;
        start16 = 1'b0; cs_sel16 = '0; tx16 = '0;
        start3 = 1'b0; cs_sel3 = '0; tx3 = '0;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 8'hA5, 1'b1, 8'h00, 8'hA5, 4'b1011};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 8'h3C, 1'b0, 8'hC3, 8'hC3, 4'b1101};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 8'h81, 1'b0, 8'h5A, 8'h5A, 4'b1110};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 8'h0F, 1'b0, 8'hF0, 8'hF0, 4'b0111};

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rx_data", rx_data, 0);
        check("reset sclk", sclk, 0);
        check("reset mosi", mosi, 0);
        check("reset cs_n", cs_n, 4'hF);
        rst = 1'b0;

        foreach (vecs[k]) apply_vec(vecs[k], $sformatf("vec%0d", k));

        // Back-to-back: start raised in cycle 10 and held until the next transfer begins.
        @(negedge clk);
        tb_pol = 1'b0; tb_pha = 1'b0; sl_loop = 1'b1;
        cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd1; tx_data = 8'h66; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 1; nd = 0; gap = 0; prev_b = 1'b1; rx1 = '0; rx2 = '0;
        for (int i = 0; i < 150; i++) begin
            if (i == 10) begin
                start = 1'b1;
                tx_data = 8'h99;
            end
            if (busy && !prev_b) begin
                rises++;
                start = 1'b0;
            end
            if (done) begin
                nd++;
                if (nd == 1) rx1 = rx_data;
                else rx2 = rx_data;
            end
            if (!busy && rises == 1 && nd == 1 && (&cs_n)) gap++;
            prev_b = busy;
            @(negedge clk);
        end
        check("b2b transfers", rises, 2);
        check("b2b done pulses", nd, 2);
        check("b2b first rx", rx1, 8'h66);
        check("b2b second rx", rx2, 8'h99);
        check("b2b cs_n high gap", gap, 2);

        // Reset in cycle 20 of a mode-2 transfer.
        tb_pol = 1'b1; tb_pha = 1'b0; sl_loop = 1'b0; sl_word = 8'h11;
        cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd0; tx_data = 8'h5C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort mid-transfer busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort sclk", sclk, 0);
        check("abort cs_n", cs_n, 4'hF);
        check("abort busy", busy, 0);
        check("abort rx_data", rx_data, 0);
        check("abort done", done, 0);
        rst = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("abort no done/busy after", nd, 0);
        apply_vec('{1'b0, 1'b0, 2'd3, 8'hC9, 1'b0, 8'h6E, 8'h6E, 4'b0111}, "post-abort");

        // Three slaves: cs_sel=3 is out of range and must be ignored.
        cpol = 1'b0; cpha = 1'b0; cs_sel3 = 2'd3; tx3 = 8'hE7; start3 = 1'b1;
        b = 0; nd = 0; gap = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy3) b++;
            if (done3) nd++;
            if (cs_n3 !== 3'b111) gap++;
        end
        check("bad cs busy", b, 0);
        check("bad cs done", nd, 0);
        check("bad cs cs_n", gap, 0);
        cs_sel3 = 2'd0;
        @(negedge clk);
        start3 = 1'b0;
        b = 0; nd = 0; gap = 0; rxd = '0;
        for (int i = 0; i < 200; i++) begin
            if (busy3) begin
                b++;
                if (cs_n3 !== 3'b110) gap++;
            end
            if (done3) begin
                nd++;
                rxd = rx3;
                break;
            end
            @(negedge clk);
        end
        check("cs3 busy cycles", b, 36);
        check("cs3 cs_n", gap, 0);
        check("cs3 done", nd, 1);
        check("cs3 rx_data", rxd, 8'hE7);

        // 16-bit LSB-first, mode 1.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b1; cs_sel16 = 2'd2; tx16 = 16'h1234; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        ps = sclk16; b = 0; nd = 0; leads = 0; first_bit_seen = 0; first_bit = 1'b1;
        cap = '0; rxd16 = '0;
        for (int i = 0; i < 300; i++) begin
            if (busy16) b++;
            if (sclk16 !== ps) begin
                if (sclk16) begin
                    leads++;
                    if (first_bit_seen == 0) begin
                        first_bit = mosi16;
                        first_bit_seen = 1;
                    end
                end else begin
                    cap = {mosi16, cap[15:1]};
                end
            end
            ps = sclk16;
            if (done16) begin
                nd++;
                rxd16 = rx16;
                break;
            end
            @(negedge clk);
        end
        check("w16 busy cycles", b, 68);
        check("w16 leading edges", leads, 16);
        check("w16 first mosi bit", first_bit, 1'b0);
        check("w16 slave received", cap, 16'h1234);
        check("w16 rx_data", rxd16, 16'h1234);
        check("w16 done", nd, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised next-generation SPI master: configurable word width, all four CPOL/CPHA modes selectable per transfer, MSB/LSB-first order, and NUM_CS one-hot chip selects.
- Sits between a register/CPU-side start/done handshake and the SPI pins.
- Replaces the fixed 8-bit, single-CS, mode-0 master in the SPI subsystem; the UVM environment drives it through a widened spi_if.

Parameters:
- DATA_W, 8, bits per transfer (2..32).
- CLK_DIV, 4, clk cycles per SCLK period; even and >=2. Half-period H = CLK_DIV/2.
- NUM_CS, 4, number of chip-select outputs (1..16).
- MSB_FIRST, 1, 1 = MSB shifted/received first, 0 = LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transfer request, level-sampled each clk.
- cpol  in  1  clock polarity, latched on accepted start.
- cpha  in  1  clock phase, latched on accepted start.
- cs_sel  in  CS_W=max(1,$clog2(NUM_CS))  target slave index, latched on accepted start.
- tx_data  in  DATA_W  word to send, latched on accepted start.
- rx_data  out  DATA_W  last received word; valid from the done cycle, held until the next done.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at end of transfer.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  NUM_CS  active-low chip selects; at most one low at any time.

Behaviour:
- Reset (clock and reset share one clk edge): busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1, state IDLE, latched cpol=0.
- Start acceptance:
  - Accepted only in IDLE when start=1 and cs_sel<NUM_CS.
  - Out-of-range cs_sel: start ignored; no busy, no done, pins unchanged.
  - start while busy: ignored.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE -> SETUP, cycle after acceptance:
  - busy=1, cs_n[cs_sel]=0, sclk=cpol.
  - CPHA=0 only: mosi = first bit.
  - SETUP lasts H cycles.
- XFER: 2*DATA_W SCLK edges, each H cycles apart; the first edge ends SETUP.
  - Leading edges toggle sclk away from cpol; trailing edges toggle it back.
  - CPHA=0: sample miso on each leading edge; update mosi on each trailing edge except the last.
  - CPHA=1: update mosi on each leading edge (first leading edge drives the first bit); sample miso on each trailing edge.
  - Bit order follows MSB_FIRST for both shifting and receive assembly.
- HOLD: after the last edge, sclk=cpol and cs_n stays low for H cycles.
- DONE: one cycle.
  - busy=0, cs_n all 1, done=1, rx_data updated to the assembled word.
  - mosi returns to 0.
  - Transition to IDLE.
- Latency: busy high for exactly (2*DATA_W+2)*H cycles; done follows in the first cycle with busy=0.
- Back-to-back: start=1 in the DONE cycle is not accepted. The earliest accept is the IDLE cycle after done, so CS deasserts for at least 1 clk between transfers.
- Idle sclk level: the last latched cpol persists between transfers. Reset forces 0.
- Reset mid-transfer:
  - Immediate abort to reset values; no done pulse.
  - rx_data cleared to 0.
  - Partial receive data discarded.
- miso is sampled from the input directly; no internal synchronizer, since the slave is synchronous to SCLK.
- Assertions (bound in spi_if):
  - cs_n onehot0 inverted.
  - done implies !busy.
  - sclk stable while cs_n all 1.

Decomposition:
- Package spi_mc_pkg: state enum (IDLE, SETUP, XFER, HOLD, DONE); spi_mode_t struct {cpol, cpha}; function clog2-safe CS_W.
- One sub-module, spi_mc_sclk_gen: half-period counter producing lead_edge/trail_edge strobes and an edge count; instantiated once.
- Shift/receive registers and FSM stay in the top.

Test Plan (DATA_W=8, CLK_DIV=4, NUM_CS=4 unless noted):
- Mode 0, cs_sel=2, tx=0xA5, miso looped to mosi -> cs_n=4'b1011 for 36 cycles, busy 36 cycles, done one pulse, rx_data=0xA5, mosi changes only while sclk low.
- Mode 3 (cpol=1, cpha=1), tx=0x3C, slave model returns 0xC3 -> sclk idles high, mosi updates on falling edges, rx_data=0xC3.
- MSB_FIRST=0, DATA_W=16, mode 1, tx=0x1234 -> first mosi bit=0 (LSB), 16 leading edges observed, slave receives 0x1234 in LSB order; busy 68 cycles.
- NUM_CS=3, cs_sel=3, start=1 -> no busy, cs_n stays 3'b111, no done. Then cs_sel=0 -> normal transfer.
- start pulsed at cycle 10 of a transfer and held through its done cycle -> no extra transfer until the cycle after done. Then exactly one new transfer, with at least 1 cycle of cs_n all-high between transfers.
- rst asserted at cycle 20 of a mode-2 transfer -> next cycle sclk=0, cs_n=4'hF, busy=0, rx_data=0, no done. A following start in mode 0 completes correctly.
